// File: rtl/centroid_track_ctrl.sv
// centroid_track_ctrl
//   Per-frame crosshair controller. Accumulates the coordinates of mask-hit
//   pixels over a frame, snapshots the sums at end of frame, then runs one
//   shared restoring divider twice (X then Y) and publishes the centroid.
//   The overlay enable drops after MISS_FRAMES consecutive frames with fewer
//   than MIN_PIXELS hits. The next frame keeps accumulating during division.
//
//   Optional: `define CENTROID_SMOOTH_EN averages each new centroid with the
//   previous one while the overlay is already enabled.
//
// Ports:
//   i_clk, i_rstn        clock, synchronous active-low reset
//   i_data_valid         pixel strobe, raster order
//   i_mask               hit flag for the current pixel
//   i_end_frame          last pixel of the frame (qualified by i_data_valid)
//   o_centroid_x/_y      published centroid
//   o_centroid_valid     one-cycle pulse per publish
//   o_overlay_en         crosshair enable level
//   o_busy               FSM is outside ACCUM
module centroid_track_ctrl #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int MIN_PIXELS  = 64,
    parameter int MISS_FRAMES = 4
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_data_valid,
    input  logic       i_mask,
    input  logic       i_end_frame,
    output logic [9:0] o_centroid_x,
    output logic [8:0] o_centroid_y,
    output logic       o_centroid_valid,
    output logic       o_overlay_en,
    output logic       o_busy
);
    localparam int SW        = 28;
    localparam int CW        = 19;
    localparam int DIV_ITERS = 28;
    localparam int MW        = $clog2(MISS_FRAMES + 1);

    localparam logic [9:0]    X_MAX     = 10'(H_ACTIVE - 1);
    localparam logic [8:0]    Y_MAX     = 9'(V_ACTIVE - 1);
    localparam logic [SW-1:0] XQ_MAX    = SW'(H_ACTIVE - 1);
    localparam logic [SW-1:0] YQ_MAX    = SW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] MIN_CNT   = CW'(MIN_PIXELS);
    localparam logic [MW-1:0] MISS_MAX  = MW'(MISS_FRAMES);
    localparam logic [MW-1:0] MISS_LAST = MW'(MISS_FRAMES - 1);
    localparam logic [4:0]    LAST_IT   = 5'(DIV_ITERS - 1);

    typedef enum logic [2:0] {ACCUM, CHECK, DIV_X, DIV_Y, PUBLISH} state_t;

    state_t state, state_nxt;

    logic [9:0]    x_cnt;
    logic [8:0]    y_cnt;
    logic [SW-1:0] sum_x, sum_y, snap_x, snap_y;
    logic [CW-1:0] cnt, snap_cnt;
    logic [MW-1:0] miss_cnt;

    // ---------------------------------------------------------------- raster
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (i_data_valid) begin
            if (i_end_frame) begin
                x_cnt <= '0;
                y_cnt <= '0;
            end else if (x_cnt == X_MAX) begin
                x_cnt <= '0;
                y_cnt <= (y_cnt == Y_MAX) ? '0 : y_cnt + 9'd1;
            end else begin
                x_cnt <= x_cnt + 10'd1;
            end
        end
    end

    // ----------------------------------------------------------- accumulate
    // Next-value of the accumulators including the current pixel, so the
    // end-of-frame pixel lands in the snapshot. Carry-out means saturate.
    logic [SW:0]   sx_add, sy_add;
    logic [CW:0]   cnt_add;
    logic [SW-1:0] sx_nxt, sy_nxt;
    logic [CW-1:0] cnt_nxt;

    always_comb begin
        sx_add  = {1'b0, sum_x} + {{(SW-9){1'b0}}, x_cnt};
        sy_add  = {1'b0, sum_y} + {{(SW-8){1'b0}}, y_cnt};
        cnt_add = {1'b0, cnt} + {{CW{1'b0}}, 1'b1};
        sx_nxt  = sum_x;
        sy_nxt  = sum_y;
        cnt_nxt = cnt;
        if (i_data_valid && i_mask) begin
            sx_nxt  = sx_add[SW]  ? '1 : sx_add[SW-1:0];
            sy_nxt  = sy_add[SW]  ? '1 : sy_add[SW-1:0];
            cnt_nxt = cnt_add[CW] ? '1 : cnt_add[CW-1:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            sum_x    <= '0;
            sum_y    <= '0;
            cnt      <= '0;
            snap_x   <= '0;
            snap_y   <= '0;
            snap_cnt <= '0;
        end else if (i_data_valid) begin
            if (i_end_frame) begin
                // A frame ending while busy is dropped, but still clears.
                sum_x <= '0;
                sum_y <= '0;
                cnt   <= '0;
                if (state == ACCUM) begin
                    snap_x   <= sx_nxt;
                    snap_y   <= sy_nxt;
                    snap_cnt <= cnt_nxt;
                end
            end else begin
                sum_x <= sx_nxt;
                sum_y <= sy_nxt;
                cnt   <= cnt_nxt;
            end
        end
    end

    // ------------------------------------------------------------------ FSM
    logic [4:0] it_cnt;
    logic       last_it, miss_frame;

    assign last_it    = (it_cnt == LAST_IT);
    assign miss_frame = (snap_cnt < MIN_CNT);

    always_ff @(posedge i_clk) begin
        if (!i_rstn) state <= ACCUM;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (i_data_valid && i_end_frame) state_nxt = CHECK;
            CHECK:   state_nxt = miss_frame ? ACCUM : DIV_X;
            DIV_X:   if (last_it) state_nxt = DIV_Y;
            DIV_Y:   if (last_it) state_nxt = PUBLISH;
            PUBLISH: state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    assign o_busy = (state != ACCUM);

    // -------------------------------------------------------------- divider
    // Restoring divider: dq shifts dividend bits out of the top while
    // quotient bits enter at the bottom; after 28 steps dq holds the quotient.
    logic [CW-1:0] rem;
    logic [SW-1:0] dq, quo_x;
    logic [CW:0]   rem_sh;
    logic          q_bit;

    assign rem_sh = {rem, dq[SW-1]};
    assign q_bit  = (rem_sh >= {1'b0, snap_cnt});

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            rem    <= '0;
            dq     <= '0;
            quo_x  <= '0;
            it_cnt <= '0;
        end else begin
            case (state)
                CHECK: begin
                    rem    <= '0;
                    dq     <= snap_x;
                    it_cnt <= '0;
                end
                DIV_X, DIV_Y: begin
                    rem    <= CW'(q_bit ? rem_sh - {1'b0, snap_cnt} : rem_sh);
                    dq     <= {dq[SW-2:0], q_bit};
                    it_cnt <= last_it ? 5'd0 : it_cnt + 5'd1;
                    if (state == DIV_X && last_it) begin
                        quo_x <= {dq[SW-2:0], q_bit};
                        rem   <= '0;
                        dq    <= snap_y;
                    end
                end
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------- publish
    logic [9:0] cx_clamp, cx_new;
    logic [8:0] cy_clamp, cy_new;

    assign cx_clamp = (quo_x > XQ_MAX) ? X_MAX : quo_x[9:0];
    assign cy_clamp = (dq > YQ_MAX)    ? Y_MAX : dq[8:0];

`ifdef CENTROID_SMOOTH_EN
    logic [10:0] sum_cx;
    logic [9:0]  sum_cy;
    assign sum_cx = {1'b0, o_centroid_x} + {1'b0, cx_clamp};
    assign sum_cy = {1'b0, o_centroid_y} + {1'b0, cy_clamp};
    assign cx_new = o_overlay_en ? 10'(sum_cx >> 1) : cx_clamp;
    assign cy_new = o_overlay_en ? 9'(sum_cy >> 1)  : cy_clamp;
`else
    assign cx_new = cx_clamp;
    assign cy_new = cy_clamp;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            o_centroid_x     <= '0;
            o_centroid_y     <= '0;
            o_centroid_valid <= 1'b0;
            o_overlay_en     <= 1'b0;
            miss_cnt         <= '0;
        end else begin
            o_centroid_valid <= 1'b0;
            if (state == CHECK && miss_frame) begin
                if (miss_cnt != MISS_MAX) miss_cnt <= miss_cnt + MW'(1);
                if (miss_cnt >= MISS_LAST) o_overlay_en <= 1'b0;
            end
            if (state == PUBLISH) begin
                o_centroid_x     <= cx_new;
                o_centroid_y     <= cy_new;
                o_centroid_valid <= 1'b1;
                o_overlay_en     <= 1'b1;
                miss_cnt         <= '0;
            end
        end
    end

    // Divisor is snap_cnt >= MIN_PIXELS, so zero would allow divide-by-zero.
    always @(posedge i_clk) begin
        assert (MIN_PIXELS > 0) else $error("centroid_track_ctrl: MIN_PIXELS must be >= 1");
    end

endmodule

// File: tb/tb_centroid_track_ctrl.sv
module tb_centroid_track_ctrl;
    localparam int H    = 64;
    localparam int V    = 48;
    localparam int MINP = 8;
    localparam int MISS = 4;

    logic       i_clk = 1'b0;
    logic       i_rstn = 1'b0;
    logic       i_data_valid = 1'b0;
    logic       i_mask = 1'b0;
    logic       i_end_frame = 1'b0;
    logic [9:0] o_centroid_x;
    logic [8:0] o_centroid_y;
    logic       o_centroid_valid;
    logic       o_overlay_en;
    logic       o_busy;

    centroid_track_ctrl #(
        .H_ACTIVE(H), .V_ACTIVE(V), .MIN_PIXELS(MINP), .MISS_FRAMES(MISS)
    ) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_data_valid(i_data_valid),
        .i_mask(i_mask), .i_end_frame(i_end_frame),
        .o_centroid_x(o_centroid_x), .o_centroid_y(o_centroid_y),
        .o_centroid_valid(o_centroid_valid), .o_overlay_en(o_overlay_en),
        .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    int nchk = 0;
    int nerr = 0;
    int pulse_cnt = 0;

    task automatic check(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------ reference model
    // Event-scheduled view: a frame end at edge E either schedules a miss
    // update visible after E+1 or a publish visible after E+58; frames ending
    // while a previous one is still in flight are dropped.
    int  edge_n = 0;
    bit  m_init = 0;
    int  px, py, msx, msy, mcnt;
    int  busy_until = -1;
    bit  pub_pend, miss_pend, miss_clear;
    int  pub_edge, miss_edge, pq_x, pq_y;
    int  m_x, m_y, m_miss;
    bit  m_ov, m_pulse;

    always @(posedge i_clk) begin
        edge_n++;
        m_pulse = 0;
        if (!i_rstn) begin
            m_init = 1;
            px = 0; py = 0; msx = 0; msy = 0; mcnt = 0;
            busy_until = -1; pub_pend = 0; miss_pend = 0;
            m_x = 0; m_y = 0; m_ov = 0; m_miss = 0;
        end else begin
            if (pub_pend && edge_n == pub_edge) begin
`ifdef CENTROID_SMOOTH_EN
                if (m_ov) begin
                    m_x = (m_x + pq_x) / 2;
                    m_y = (m_y + pq_y) / 2;
                end else begin
                    m_x = pq_x;
                    m_y = pq_y;
                end
`else
                m_x = pq_x;
                m_y = pq_y;
`endif
                m_ov = 1; m_pulse = 1; pub_pend = 0;
            end
            if (miss_pend && edge_n == miss_edge) begin
                if (miss_clear) m_ov = 0;
                miss_pend = 0;
            end
            if (i_data_valid) begin
                if (i_mask) begin
                    msx += px; msy += py; mcnt++;
                end
                if (i_end_frame) begin
                    if (edge_n - 1 > busy_until) begin
                        if (mcnt < MINP) begin
                            m_miss = (m_miss + 1 > MISS) ? MISS : m_miss + 1;
                            miss_clear = (m_miss == MISS);
                            miss_pend = 1; miss_edge = edge_n + 1;
                            busy_until = edge_n;
                        end else begin
                            pq_x = (msx / mcnt > H - 1) ? H - 1 : msx / mcnt;
                            pq_y = (msy / mcnt > V - 1) ? V - 1 : msy / mcnt;
                            pub_pend = 1; pub_edge = edge_n + 58;
                            busy_until = edge_n + 57;
                            m_miss = 0;
                        end
                    end
                    msx = 0; msy = 0; mcnt = 0; px = 0; py = 0;
                end else begin
                    px++;
                    if (px == H) begin
                        px = 0;
                        py = (py + 1) % V;
                    end
                end
            end
        end
    end

    always @(negedge i_clk) begin
        if (m_init) begin
            check("valid", int'(o_centroid_valid), int'(m_pulse));
            check("busy", int'(o_busy), int'(edge_n <= busy_until));
            check("overlay", int'(o_overlay_en), int'(m_ov));
            check("cx", int'(o_centroid_x), m_x);
            check("cy", int'(o_centroid_y), m_y);
            pulse_cnt += int'(o_centroid_valid);
        end
    end

    // -------------------------------------------------------------- stimulus
    task automatic drive(input logic v, input logic m, input logic ef);
        @(posedge i_clk);
        #1;
        i_data_valid = v;
        i_mask       = m;
        i_end_frame  = ef;
    endtask

    // dens < 0: mask is the rectangle; otherwise random hit percentage.
    task automatic send_frame(input int npix, input int x0, input int y0,
                              input int w, input int h, input int dens, input bit gaps);
        for (int i = 0; i < npix; i++) begin
            int  x, y;
            logic m;
            if (gaps) while ($urandom_range(3) == 0) drive(1'b0, 1'b0, 1'b0);
            x = i % H;
            y = (i / H) % V;
            if (dens < 0) m = (x >= x0 && x < x0 + w && y >= y0 && y < y0 + h);
            else          m = ($urandom_range(99) < dens);
            drive(1'b1, m, i == npix - 1);
        end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
    endtask

    typedef struct {
        int npix; int x0; int y0; int w; int h;
        int ex; int ey; int det; int eov;
    } vec_t;

    vec_t tbl[11];

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int p0;
        tbl[0]  = '{768,  19,  9,  3, 3, 20, 10, 1, 1};  // 3x3 blob
        tbl[1]  = '{576,  30,  5,  2, 4, 30,  6, 1, 1};  // exactly MIN hits
        tbl[2]  = '{3072,  0,  0, 64, 48, 31, 23, 1, 1}; // whole frame
        tbl[3]  = '{3264,  0,  0, 64, 2, 31,  0, 1, 1};  // y wraps past V-1
        tbl[4]  = '{192,  10,  2,  7, 1, 31,  0, 0, 1};  // MIN-1 hits: miss 1
        tbl[5]  = '{256,   0,  3,  5, 1, 31,  0, 0, 1};  // miss 2
        tbl[6]  = '{256,   0,  3,  5, 1, 31,  0, 0, 1};  // miss 3
        tbl[7]  = '{256,   0,  3,  5, 1, 31,  0, 0, 0};  // miss 4: overlay off
        tbl[8]  = '{256,   0,  3,  5, 1, 31,  0, 0, 0};  // miss saturated
        tbl[9]  = '{2112, 40, 30,  5, 3, 42, 31, 1, 1};  // re-enable
        tbl[10] = '{128,  60,  0,  4, 2, 61,  0, 1, 1};  // right edge

        idle(3);
        i_rstn = 1'b1;
        @(negedge i_clk);
        check("rst_x", int'(o_centroid_x), 0);
        check("rst_valid", int'(o_centroid_valid), 0);
        check("rst_ovl", int'(o_overlay_en), 0);
        check("rst_busy", int'(o_busy), 0);

        for (int i = 0; i < 11; i++) begin
            p0 = pulse_cnt;
            send_frame(tbl[i].npix, tbl[i].x0, tbl[i].y0, tbl[i].w, tbl[i].h, -1, 1'b1);
            idle(70);
            @(negedge i_clk);
            check($sformatf("tbl%0d_pulses", i), pulse_cnt - p0, tbl[i].det);
            check($sformatf("tbl%0d_ovl", i), int'(o_overlay_en), tbl[i].eov);
`ifndef CENTROID_SMOOTH_EN
            check($sformatf("tbl%0d_x", i), int'(o_centroid_x), tbl[i].ex);
            check($sformatf("tbl%0d_y", i), int'(o_centroid_y), tbl[i].ey);
`endif
        end

        // Second end_frame 10 cycles after the first, while busy: dropped.
        p0 = pulse_cnt;
        send_frame(768, 19, 9, 3, 3, -1, 1'b1);
        idle(8);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        idle(70);
        @(negedge i_clk);
        check("ovlp_pulses", pulse_cnt - p0, 1);
        check("ovlp_x", int'(o_centroid_x), 20);
        check("ovlp_y", int'(o_centroid_y), 10);
        // A leaked hit at (0,0) would pull this result off (42,31).
        p0 = pulse_cnt;
        send_frame(2112, 40, 30, 5, 3, -1, 1'b0);
        idle(70);
        @(negedge i_clk);
        check("ovlp_next_pulses", pulse_cnt - p0, 1);
        check("ovlp_next_x", int'(o_centroid_x), 42);
        check("ovlp_next_y", int'(o_centroid_y), 31);

        // Reset during DIV_X aborts the division.
        send_frame(576, 30, 5, 2, 4, -1, 1'b0);
        idle(18);
        @(posedge i_clk); #1 i_rstn = 1'b0;
        @(posedge i_clk); #1 i_rstn = 1'b1;
        @(negedge i_clk);
        check("rstdiv_busy", int'(o_busy), 0);
        check("rstdiv_ovl", int'(o_overlay_en), 0);
        check("rstdiv_x", int'(o_centroid_x), 0);
        check("rstdiv_y", int'(o_centroid_y), 0);
        p0 = pulse_cnt;
        idle(70);
        @(negedge i_clk);
        check("rstdiv_nopulse", pulse_cnt - p0, 0);
        send_frame(768, 19, 9, 3, 3, -1, 1'b1);
        idle(70);
        @(negedge i_clk);
        check("rstdiv_after_pulses", pulse_cnt - p0, 1);
        check("rstdiv_after_x", int'(o_centroid_x), 20);
        check("rstdiv_after_ovl", int'(o_overlay_en), 1);

        // Random frames, random densities and gaps; short idles let frames
        // land while busy. Checked cycle-by-cycle against the model.
        for (int r = 0; r < 14; r++) begin
            send_frame($urandom_range(200, 1500), 0, 0, 0, 0,
                       int'($urandom_range(0, 4) == 0 ? $urandom_range(10, 60)
                                                      : $urandom_range(0, 3)), 1'b1);
            idle($urandom_range(0, 80));
        end
        idle(80);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/centroid_track_ctrl.md
Name: centroid_track_ctrl

Overview:
Per-frame controller that generates the crosshair overlay's centroid position and enable. It accumulates the coordinates of mask-hit pixels over each 640x480 frame. At end of frame it snapshots the sums and runs one shared sequential divider twice, first for X and then for Y. It then publishes the centroid and manages overlay enable with a miss-frame timeout. Accumulation of the next frame continues while the division runs.

Parameters:
H_ACTIVE, 640, active pixels per line; the x counter wraps at H_ACTIVE-1.
V_ACTIVE, 480, active lines per frame; the y counter wraps at V_ACTIVE-1.
MIN_PIXELS, 64, minimum hit count for a frame to count as a detection.
MISS_FRAMES, 4, consecutive non-detection frames before overlay is disabled.

Ports:
i_clk  in  1  clock
i_rstn  in  1  reset, synchronous, active-low
i_data_valid  in  1  pixel strobe; one pixel per valid cycle, raster order
i_mask  in  1  detection mask for the current pixel; sampled only when valid
i_end_frame  in  1  marks the last pixel of a frame; qualified by i_data_valid
o_centroid_x  out  10  published centroid X
o_centroid_y  out  9  published centroid Y
o_centroid_valid  out  1  one-cycle pulse when a new centroid is published
o_overlay_en  out  1  level; crosshair drawing enable
o_busy  out  1  high while the FSM is not in ACCUM

Behaviour:
- Reset (i_rstn=0 at a clock edge):
  - All outputs go to 0.
  - All counters, accumulators and miss_cnt go to 0.
  - FSM goes to ACCUM.
  - Any division in flight is aborted and produces no pulse.
- Position counters (x_cnt, y_cnt):
  - Advance on each valid pixel; x wraps at H_ACTIVE-1, and y increments on that wrap.
  - y wraps at V_ACTIVE-1.
  - A valid pixel with i_end_frame forces both counters to 0 on the next edge.
- Accumulators: sum_x 28b, sum_y 28b, cnt 19b.
  - On a valid pixel with i_mask=1, add x_cnt and y_cnt to the sums and increment cnt.
  - Accumulators saturate and never wrap.
- End of frame (valid & end_frame in cycle T):
  - The T pixel is included in the frame's accumulation.
  - The final sums and count are copied to the snapshot registers.
  - The accumulators clear, so the next valid pixel starts from 0.
  - If the FSM is in ACCUM, it moves to CHECK.
  - If the FSM is busy, the snapshot is not taken, the frame is discarded, miss_cnt is unchanged and the accumulators still clear.
- FSM states:
  - ACCUM: idle, waiting for end of frame.
  - CHECK (cycle T+1):
    - If snap_cnt < MIN_PIXELS: miss_cnt increments (saturating at MISS_FRAMES), then ACCUM.
    - Reaching MISS_FRAMES clears o_overlay_en on the same edge. The centroid outputs hold their value and there is no pulse.
    - Otherwise go to DIV_X.
  - DIV_X (T+2..T+29): restoring division snap_sum_x / snap_cnt, one quotient bit per cycle, 28 iterations.
  - DIV_Y (T+30..T+57): same divider hardware, computing snap_sum_y / snap_cnt.
  - PUBLISH (T+58): register the quotients into the outputs, set o_overlay_en=1 and clear miss_cnt.
- Publish timing and arithmetic:
  - o_centroid_valid=1 in cycle T+59 only, which is a fixed latency of 59 cycles.
  - The FSM is back in ACCUM at T+59.
  - Quotients are floor division.
  - Results are clamped to H_ACTIVE-1 and V_ACTIVE-1 before truncation to 10 and 9 bits.
- o_busy is 1 in CHECK, DIV_X, DIV_Y and PUBLISH.
- Division by zero cannot occur, because MIN_PIXELS must be at least 1. The design asserts on MIN_PIXELS=0 in simulation.

Optional Feature:
CENTROID_SMOOTH_EN
- Defined: in PUBLISH, if o_overlay_en is already 1, the new output is (old + new) >> 1, computed with 1 extra bit before the shift. If o_overlay_en is 0, the new value is loaded directly. Latency is unchanged.
- Undefined: the new quotient is loaded directly every time.

Test Plan:
- 3x3 blob centred at (100,50), MIN_PIXELS=4, end_frame at cycle T -> o_centroid_valid at T+59 only, centroid (100,50), overlay_en=1, busy high T+1..T+58.
- Full frame with mask=1 everywhere -> centroid (319,239) (floor of 319.5 and 239.5), cnt=307200 with no saturation.
- Detection frame followed by 4 frames with 10 hit pixels each (MIN_PIXELS=64) -> no pulses, centroid held, overlay_en falls at the CHECK of the 4th miss frame; the next valid frame re-enables it.
- Second end_frame at T+10 while busy -> only one pulse at T+59 with the first frame's result, accumulators cleared at T+11, miss_cnt unchanged.
- Reset asserted at T+20 during DIV_X -> at T+21 all outputs are 0 and FSM is in ACCUM, no pulse follows, and the next frame publishes normally.
- CENTROID_SMOOTH_EN defined, frames centred at (100,50) then (200,150) -> second publish gives (150,100).
